// File: rtl/pixel_ctrl_pkg.sv
// Shared types and default phase lengths for the pixel array sequencer.
package pixel_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ERASE   = 3'd1,
    S_EXPOSE  = 3'd2,
    S_CONVERT = 3'd3,
    S_READ1   = 3'd4,
    S_READ2   = 3'd5,
    S_GAP     = 3'd6
  } state_t;

  localparam int unsigned DEF_ERASE   = 5;
  localparam int unsigned DEF_EXPOSE  = 255;
  localparam int unsigned DEF_CONVERT = 255;
  localparam int unsigned DEF_READ    = 5;

  // Phase that follows the gap after phase p; the READ2 gap is decided by en.
  function automatic state_t phase_after(input state_t p);
    case (p)
      S_ERASE:   return S_EXPOSE;
      S_EXPOSE:  return S_CONVERT;
      S_CONVERT: return S_READ1;
      S_READ1:   return S_READ2;
      default:   return S_ERASE;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// 16-bit down-counter timing a single phase; expire marks the last phase cycle.
module phase_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic        expire
);

  logic [15:0] count;

  // NOTE: async reset in the sensitivity list, non-blocking updates for all state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 16'd0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 16'd0) begin
      count <= count - 16'd1;
    end
  end

  assign expire = (count == 16'd0);

endmodule

// File: rtl/pixel_seq_ctrl.sv
// Pixel array frame sequencer: erase/expose/convert/read phases with gaps,
// ADC ramp during convert, pixel pair capture and frame counting.
module pixel_seq_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int unsigned C_ERASE   = DEF_ERASE,
  parameter int unsigned C_EXPOSE  = DEF_EXPOSE,
  parameter int unsigned C_CONVERT = DEF_CONVERT,
  parameter int unsigned C_READ    = DEF_READ
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        abort,
  output logic        erase,
  output logic        expose,
  output logic        convert,
  output logic        read1,
  output logic        read2,
  output logic [7:0]  adc_code,
  input  logic [7:0]  pix_in1,
  input  logic [7:0]  pix_in2,
  output logic [7:0]  pix_out1,
  output logic [7:0]  pix_out2,
  output logic        pix_valid,
  output logic        pix_row,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  state_t      state, state_nxt, last_phase;
  logic        timer_load, timer_expire;
  logic [15:0] timer_val;
  logic        capture, frame_end;

  // Timer is loaded with length-1 so expire coincides with the last phase cycle.
  function automatic logic [15:0] len_m1(input state_t p);
    case (p)
      S_ERASE:          return 16'(C_ERASE - 1);
      S_EXPOSE:         return 16'(C_EXPOSE - 1);
      S_CONVERT:        return 16'(C_CONVERT - 1);
      S_READ1, S_READ2: return 16'(C_READ - 1);
      default:          return 16'd0;
    endcase
  endfunction

  phase_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .expire   (timer_expire)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (en) state_nxt = S_ERASE;
        S_GAP:   if (last_phase == S_READ2) state_nxt = en ? S_ERASE : S_IDLE;
                 else state_nxt = phase_after(last_phase);
        default: if (timer_expire) state_nxt = S_GAP;
      endcase
    end
    timer_load = (state == S_IDLE || state == S_GAP) && (state_nxt != S_IDLE);
    timer_val  = len_m1(state_nxt);
    capture    = !abort && timer_expire && (state == S_READ1 || state == S_READ2);
    frame_end  = !abort && timer_expire && (state == S_READ2);
  end

  // Outputs are decoded from the next state so they are registered with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      last_phase <= S_ERASE;
      erase      <= 1'b0;
      expose     <= 1'b0;
      convert    <= 1'b0;
      read1      <= 1'b0;
      read2      <= 1'b0;
      busy       <= 1'b0;
      adc_code   <= 8'd0;
      pix_out1   <= 8'd0;
      pix_out2   <= 8'd0;
      pix_row    <= 1'b0;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= 16'd0;
    end else begin
      state <= state_nxt;
      if (state != S_IDLE && state != S_GAP) last_phase <= state;
      erase   <= (state_nxt == S_ERASE);
      expose  <= (state_nxt == S_EXPOSE);
      convert <= (state_nxt == S_CONVERT);
      read1   <= (state_nxt == S_READ1);
      read2   <= (state_nxt == S_READ2);
      busy    <= (state_nxt != S_IDLE);
      if (state == S_CONVERT && state_nxt == S_CONVERT)
        adc_code <= (adc_code == 8'hFF) ? 8'hFF : adc_code + 8'd1;
      else
        adc_code <= 8'd0;
      pix_valid <= capture;
      if (capture) begin
        pix_out1 <= pix_in1;
        pix_out2 <= pix_in2;
        pix_row  <= (state == S_READ2);
      end
      frame_done <= frame_end;
      if (frame_end) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pixel_seq_ctrl.sv
// Scoreboard bench for pixel_seq_ctrl: a schedule-based frame model predicts
// every cycle plus capture/frame events, a negedge monitor compares them.
module tb_pixel_seq_ctrl;

  localparam int unsigned C_ERASE   = 2;
  localparam int unsigned C_EXPOSE  = 4;
  localparam int unsigned C_CONVERT = 4;
  localparam int unsigned C_READ    = 2;

  typedef enum {P_IDLE, P_ERASE, P_EXPOSE, P_CONVERT, P_READ1, P_READ2, P_GAP} ph_t;
  typedef struct {
    ph_t        ph;
    logic [7:0] adc;
    bit         last_read;
    bit         row;
    bit         frame_end;
  } slot_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0, abort = 1'b0;
  logic [7:0]  pix_in1 = 8'd0, pix_in2 = 8'd0;
  logic        erase, expose, convert, read1, read2, pix_valid, pix_row, busy, frame_done;
  logic [7:0]  adc_code, pix_out1, pix_out2;
  logic [15:0] frame_cnt;
  logic [46:0] dut_vec;

  int checks = 0;
  int errors = 0;

  // Reference model state
  slot_t       sched[$];
  slot_t       cur;
  logic [15:0] m_cnt = 16'd0;
  logic [7:0]  m_po1 = 8'd0, m_po2 = 8'd0;
  logic        m_row = 1'b0;
  logic [46:0] exp_cyc[$];
  logic [16:0] exp_pix[$];
  logic [15:0] exp_frame[$];

  pixel_seq_ctrl #(
    .C_ERASE(C_ERASE), .C_EXPOSE(C_EXPOSE), .C_CONVERT(C_CONVERT), .C_READ(C_READ)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .abort(abort),
    .erase(erase), .expose(expose), .convert(convert), .read1(read1), .read2(read2),
    .adc_code(adc_code), .pix_in1(pix_in1), .pix_in2(pix_in2),
    .pix_out1(pix_out1), .pix_out2(pix_out2), .pix_valid(pix_valid), .pix_row(pix_row),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  assign dut_vec = {erase, expose, convert, read1, read2, busy, adc_code,
                    frame_cnt, pix_out1, pix_out2, pix_row};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic slot_t idle_slot();
    slot_t s;
    s.ph = P_IDLE; s.adc = 8'd0; s.last_read = 1'b0; s.row = 1'b0; s.frame_end = 1'b0;
    return s;
  endfunction

  function automatic logic [46:0] make_vec();
    return {cur.ph == P_ERASE, cur.ph == P_EXPOSE, cur.ph == P_CONVERT,
            cur.ph == P_READ1, cur.ph == P_READ2, cur.ph != P_IDLE, cur.adc,
            m_cnt, m_po1, m_po2, m_row};
  endfunction

  // One frame = each phase for its length, each followed by a single gap slot.
  task automatic build_frame();
    int    lens[5];
    ph_t   phs[5];
    slot_t s;
    lens = '{C_ERASE, C_EXPOSE, C_CONVERT, C_READ, C_READ};
    phs  = '{P_ERASE, P_EXPOSE, P_CONVERT, P_READ1, P_READ2};
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < lens[p]; k++) begin
        s = idle_slot();
        s.ph = phs[p];
        if (phs[p] == P_CONVERT) s.adc = (k > 255) ? 8'hFF : 8'(k);
        s.last_read = (p >= 3) && (k == lens[p] - 1);
        s.row = (p == 4);
        sched.push_back(s);
      end
      s = idle_slot();
      s.ph = P_GAP;
      s.frame_end = (p == 4);
      sched.push_back(s);
    end
  endtask

  task automatic model_step();
    slot_t prev;
    prev = cur;
    if (abort) begin
      sched.delete();
      cur = idle_slot();
    end else begin
      if (prev.last_read) begin
        m_po1 = pix_in1; m_po2 = pix_in2; m_row = prev.row;
        exp_pix.push_back({pix_in1, pix_in2, prev.row});
      end
      if (sched.size() == 0 && en) build_frame();
      if (sched.size() > 0) cur = sched.pop_front();
      else cur = idle_slot();
      if (cur.frame_end) begin
        m_cnt++;
        exp_frame.push_back(m_cnt);
      end
    end
    exp_cyc.push_back(make_vec());
  endtask

  task automatic model_clear();
    sched.delete(); exp_cyc.delete(); exp_pix.delete(); exp_frame.delete();
    cur = idle_slot();
    m_cnt = 16'd0; m_po1 = 8'd0; m_po2 = 8'd0; m_row = 1'b0;
  endtask

  initial cur = idle_slot();

  initial forever begin
    @(posedge clk);
    if (reset) begin
      cur = idle_slot();
      exp_cyc.push_back(make_vec());
    end else begin
      model_step();
    end
  end

  initial forever begin
    @(posedge reset);
    model_clear();
  end

  // Monitor: compare predicted cycle state and pop events when the DUT strobes.
  initial forever begin
    logic [46:0] ev;
    logic [16:0] pv;
    logic [15:0] fv;
    @(negedge clk);
    if (exp_cyc.size() > 0) begin
      ev = exp_cyc.pop_front();
      check("cycle_outputs", 64'(dut_vec), 64'(ev));
    end
    check("pix_valid", 64'(pix_valid), 64'(exp_pix.size() != 0));
    if (pix_valid && exp_pix.size() > 0) begin
      pv = exp_pix.pop_front();
      check("pix_capture", 64'({pix_out1, pix_out2, pix_row}), 64'(pv));
    end
    check("frame_done", 64'(frame_done), 64'(exp_frame.size() != 0));
    if (frame_done && exp_frame.size() > 0) begin
      fv = exp_frame.pop_front();
      check("frame_cnt_at_done", 64'(frame_cnt), 64'(fv));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int n, vcnt, done;

    // Reset state
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    check("reset_state", 64'(dut_vec), 64'(0));
    repeat (4) step();
    check("idle_without_en", 64'(busy), 64'(0));

    // Single frame with directed capture values
    pix_in1 = 8'h3A; pix_in2 = 8'hC5; en = 1'b1;
    step();
    en = 1'b0;
    n = 1; vcnt = 0;
    while (!frame_done && n < 40) begin
      if (pix_valid) begin
        if (vcnt == 0) check("capture_read1", 64'({pix_out1, pix_out2, pix_row}), 64'({8'h3A, 8'hC5, 1'b0}));
        vcnt++;
      end
      if (read2) begin pix_in1 = 8'h11; pix_in2 = 8'h22; end
      step();
      n++;
    end
    if (pix_valid) vcnt++;
    // n counts cycles after the start cycle, so frame_done lands on cycle 20.
    check("frame_done_cycle", 64'(n + 1), 64'(20));
    check("pix_valid_count", 64'(vcnt), 64'(2));
    check("capture_read2", 64'({pix_out1, pix_out2, pix_row}), 64'({8'h11, 8'h22, 1'b1}));
    check("frame_cnt_one", 64'(frame_cnt), 64'(1));
    repeat (3) step();
    check("idle_after_frame", 64'(busy), 64'(0));

    // Abort on the second expose cycle
    en = 1'b1;
    step();
    en = 1'b0;
    for (int i = 0; i < 20 && !expose; i++) step();
    check("expose_reached", 64'(expose), 64'(1));
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_outputs", 64'({erase, expose, convert, read1, read2, busy, adc_code}), 64'(0));
    check("abort_frame_cnt", 64'(frame_cnt), 64'(1));
    check("abort_no_valid", 64'(pix_valid), 64'(0));
    repeat (2) step();
    check("abort_stays_idle", 64'(busy), 64'(0));

    // Continuous run: three frames back to back, then en dropped mid-frame four
    en = 1'b1;
    done = 0;
    for (int i = 0; i < 200 && done < 3; i++) begin
      pix_in1 = 8'($urandom); pix_in2 = 8'($urandom);
      step();
      if (frame_done) done++;
    end
    check("three_frames", 64'(done), 64'(3));
    step();
    check("erase_after_done", 64'(erase), 64'(1));
    repeat (3) step();
    en = 1'b0;
    for (int i = 0; i < 60 && busy; i++) step();
    check("frame4_completes", 64'({busy, frame_cnt}), 64'({1'b0, 16'd5}));

    // Asynchronous reset in the middle of convert
    en = 1'b1;
    step();
    en = 1'b0;
    for (int i = 0; i < 40 && !convert; i++) step();
    check("convert_reached", 64'(convert), 64'(1));
    step();
    #1 reset = 1'b1;
    #1 check("async_reset_outputs", 64'({dut_vec, pix_valid, frame_done}), 64'(0));
    repeat (2) step();
    #1 reset = 1'b0;
    repeat (5) step();
    check("idle_after_reset", 64'(busy), 64'(0));
    en = 1'b1;
    step();
    check("start_after_reset", 64'(erase), 64'(1));

    // Randomized traffic with occasional aborts
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 3) != 0);
      abort = ($urandom_range(0, 39) == 0);
      pix_in1 = 8'($urandom); pix_in2 = 8'($urandom);
      step();
    end
    en = 1'b0; abort = 1'b0;
    for (int i = 0; i < 60 && busy; i++) step();
    check("final_idle", 64'(busy), 64'(0));
    repeat (2) step();
    check("pix_events_drained", 64'(exp_pix.size()), 64'(0));
    check("frame_events_drained", 64'(exp_frame.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
